// File: rtl/adc_spi_reader_if.sv
// Parallel-side and SPI-pin bundle for adc_spi_reader.
// slave = the reader itself; master = the requesting/ADC-facing environment.
interface adc_spi_reader_if #(
  parameter int DATA_BITS = 12
);
  logic                 start;
  logic                 busy;
  logic [DATA_BITS-1:0] sample;
  logic                 sample_valid;
  logic                 frame_err;
  logic                 cs_n;
  logic                 sck;
  logic                 miso;

  modport slave (
    input  start, miso,
    output busy, sample, sample_valid, frame_err, cs_n, sck
  );

  modport master (
    output start, miso,
    input  busy, sample, sample_valid, frame_err, cs_n, sck
  );
endinterface

// File: rtl/adc_spi_reader.sv
// SPI mode-0 master reading one MCP3201-style sample per start request.
// Optional null-bit checking is enabled by defining ADC_SPI_NULLBIT_CHECK_EN.
module adc_spi_reader #(
  parameter int CLK_DIV   = 4,
  parameter int DATA_BITS = 12,
  parameter int LEAD_BITS = 3,
  parameter int CS_SETUP  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  adc_spi_reader_if.slave   bus
);

  localparam int N       = LEAD_BITS + DATA_BITS;
  localparam int CNT_MAX = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(N + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [N-1:0]         shift_q, shift_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sck_q, sck_d;
  logic                 busy_q, busy_d;
  logic [DATA_BITS-1:0] sample_q, sample_d;
  logic                 valid_q, valid_d;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      busy_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    cs_n_d   = cs_n_q;
    sck_d    = sck_q;
    busy_d   = busy_q;
    sample_d = sample_q;
    valid_d  = 1'b0;

    unique case (state_q)
      // DONE shares IDLE's accept path so back-to-back frames keep cs_n high
      // for exactly the one DONE cycle.
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sck_q) begin
            // Capture on the edge that raises sck; the ADC changed miso on the
            // previous falling edge, so it has had a full low phase to settle.
            sck_d   = 1'b1;
            shift_d = {shift_q[N-2:0], bus.miso};
          end else begin
            sck_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d  = DONE;
              cs_n_d   = 1'b1;
              busy_d   = 1'b0;
              valid_d  = 1'b1;
              sample_d = shift_q[DATA_BITS-1:0];
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef ADC_SPI_NULLBIT_CHECK_EN
  // Null bit sits just above the data field; it must read back as 0.
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (valid_d) begin
      err_q <= shift_q[DATA_BITS];
    end
  end

  assign bus.frame_err = err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.cs_n         = cs_n_q;
  assign bus.sck          = sck_q;
  assign bus.busy         = busy_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader with a behavioural MCP3201-style ADC model.
// Covers both builds: frame_err expectation follows ADC_SPI_NULLBIT_CHECK_EN.
module tb_adc_spi_reader;

  localparam int N = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adc_spi_reader_if #(.DATA_BITS(12)) bus ();

  adc_spi_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ADC model: frame_bits = {2 acquisition bits, null bit, 12 data bits},
  // shifted out MSB first, advancing on every sck falling edge.
  logic [N-1:0] frame_bits  = '0;
  int           bit_idx     = 0;
  int           sck_rises   = 0;
  int           valid_count = 0;
  logic         sck_prev    = 1'b0;
  logic         cs_prev     = 1'b1;
  logic [3:0]   pos;

  always @(negedge clk) begin
    if (cs_prev === 1'b1 && bus.cs_n === 1'b0) begin
      bit_idx   = 0;
      sck_rises = 0;
    end
    if (sck_prev === 1'b0 && bus.sck === 1'b1) sck_rises++;
    if (sck_prev === 1'b1 && bus.sck === 1'b0) bit_idx++;
    if (bus.sample_valid === 1'b1) valid_count++;
    sck_prev = bus.sck;
    cs_prev  = bus.cs_n;
    if (bit_idx < N) begin
      pos      = 4'(N - 1 - bit_idx);
      bus.miso = frame_bits[pos];
    end else begin
      bus.miso = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start; the edge that accepts it is edge 1 of the frame.
  task automatic start_frame(input string tag);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check({tag, "_accept_cs_n"}, 32'(bus.cs_n), 32'd0);
    check({tag, "_accept_busy"}, 32'(bus.busy), 32'd1);
  endtask

  // Runs from edge from_edge to completion; valid is expected after edge 123.
  task automatic finish_frame(input string tag, input int from_edge,
                              input logic [11:0] exp_sample, input logic exp_err);
    int v0;
    v0 = valid_count;
    repeat (122 - from_edge) @(posedge clk);
    #1 check({tag, "_valid_early"}, 32'(bus.sample_valid), 32'd0);
    check({tag, "_busy_e122"}, 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1 check({tag, "_valid_123"}, 32'(bus.sample_valid), 32'd1);
    check({tag, "_sample"}, 32'(bus.sample), 32'(exp_sample));
    check({tag, "_cs_n_done"}, 32'(bus.cs_n), 32'd1);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_sck_done"}, 32'(bus.sck), 32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'(exp_err));
    check({tag, "_sck_rises"}, 32'(sck_rises), 32'd15);
    @(posedge clk);
    #1 check({tag, "_valid_drop"}, 32'(bus.sample_valid), 32'd0);
    check({tag, "_valid_count"}, 32'(valid_count - v0), 32'd1);
    check({tag, "_sample_hold"}, 32'(bus.sample), 32'(exp_sample));
  endtask

  logic exp_null_err;

  initial begin
    int v0;
`ifdef ADC_SPI_NULLBIT_CHECK_EN
    exp_null_err = 1'b1;
`else
    exp_null_err = 1'b0;
`endif
    rst_n     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(bus.cs_n), 32'd1);
    check("rst_sck", 32'(bus.sck), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sample", 32'(bus.sample), 32'd0);
    check("rst_valid", 32'(bus.sample_valid), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame: acquisition bits high to prove they are discarded.
    frame_bits = {2'b11, 1'b0, 12'hA5C};
    start_frame("f_a5c");
    finish_frame("f_a5c", 1, 12'hA5C, 1'b0);

    // start pulsed at edge 40 of an active frame must be ignored.
    frame_bits = {2'b00, 1'b0, 12'h5A3};
    start_frame("f_ign");
    repeat (38) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("f_ign_busy_e40", 32'(bus.busy), 32'd1);
    check("f_ign_cs_n_e40", 32'(bus.cs_n), 32'd0);
    finish_frame("f_ign", 40, 12'h5A3, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("f_ign_not_queued", 32'(bus.busy), 32'd0);

    // Reset at edge 60 aborts the frame with no strobe.
    frame_bits = {2'b10, 1'b0, 12'h777};
    start_frame("f_rst");
    repeat (58) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("f_rst_cs_n", 32'(bus.cs_n), 32'd1);
    check("f_rst_sck", 32'(bus.sck), 32'd0);
    check("f_rst_busy", 32'(bus.busy), 32'd0);
    check("f_rst_sample", 32'(bus.sample), 32'd0);
    check("f_rst_valid", 32'(bus.sample_valid), 32'd0);
    rst_n = 1'b1;
    v0 = valid_count;
    repeat (150) @(posedge clk);
    #1 check("f_rst_no_strobe", 32'(valid_count - v0), 32'd0);
    check("f_rst_idle_cs_n", 32'(bus.cs_n), 32'd1);

    // start held high: 0xFFF then 0x000 back-to-back.
    frame_bits = {2'b11, 1'b0, 12'hFFF};
    v0 = valid_count;
    bus.start = 1'b1;
    @(posedge clk);
    #1 check("b2b_accept_cs_n", 32'(bus.cs_n), 32'd0);
    repeat (121) @(posedge clk);
    #1 check("b2b_f1_valid_early", 32'(bus.sample_valid), 32'd0);
    @(posedge clk);
    #1 check("b2b_f1_valid", 32'(bus.sample_valid), 32'd1);
    check("b2b_f1_sample", 32'(bus.sample), 32'hFFF);
    check("b2b_f1_cs_n", 32'(bus.cs_n), 32'd1);
    check("b2b_f1_sck_rises", 32'(sck_rises), 32'd15);
    frame_bits = {2'b11, 1'b0, 12'h000};
    @(posedge clk);
    #1 check("b2b_gap_cs_n", 32'(bus.cs_n), 32'd0);
    check("b2b_gap_valid", 32'(bus.sample_valid), 32'd0);
    check("b2b_gap_busy", 32'(bus.busy), 32'd1);
    repeat (121) @(posedge clk);
    #1 check("b2b_f2_valid_early", 32'(bus.sample_valid), 32'd0);
    @(posedge clk);
    #1 check("b2b_f2_valid", 32'(bus.sample_valid), 32'd1);
    check("b2b_f2_sample", 32'(bus.sample), 32'h000);
    check("b2b_f2_cs_n", 32'(bus.cs_n), 32'd1);
    check("b2b_f2_sck_rises", 32'(sck_rises), 32'd15);
    bus.start = 1'b0;
    @(posedge clk);
    #1 check("b2b_end_cs_n", 32'(bus.cs_n), 32'd1);
    check("b2b_end_busy", 32'(bus.busy), 32'd0);
    check("b2b_valid_count", 32'(valid_count - v0), 32'd2);
    repeat (4) @(posedge clk);
    #1 check("b2b_idle_busy", 32'(bus.busy), 32'd0);

    // Null bit set: flagged only when the check is built in; clean frame clears it.
    frame_bits = {2'b00, 1'b1, 12'h123};
    start_frame("f_null");
    finish_frame("f_null", 1, 12'h123, exp_null_err);
    frame_bits = {2'b00, 1'b0, 12'h456};
    start_frame("f_clean");
    finish_frame("f_clean", 1, 12'h456, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
